// File: rtl/spi_byte_queue.sv
// Host-side byte queue for the spi master: TX FIFO feeds one spi transfer per byte,
// received bytes land in an RX FIFO. Both host sides are valid/ready streams.
module spi_byte_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [7:0]        spi_data_in,
    output logic              spi_ready_send,
    input  logic              spi_ss,
    input  logic [7:0]        spi_data_out,
    output logic              busy,
    output logic [ADDR_W:0]   tx_count,
    output logic [ADDR_W:0]   rx_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        XFER  = 2'd2,
        STORE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W + 1)'(1);

    state_t state, state_next;

    logic [7:0]      tx_mem [DEPTH];
    logic [7:0]      rx_mem [DEPTH];
    logic [ADDR_W:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, tx_pop, rx_push, rx_pop;

    assign tx_count = tx_wr - tx_rd;
    assign rx_count = rx_wr - rx_rd;
    assign tx_full  = (tx_count == FULL_COUNT);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign rx_empty = (rx_count == '0);

    // A launch needs a TX byte and guaranteed RX space, so the STORE push never overflows.
    assign tx_pop  = (state == IDLE) && !tx_empty && !rx_full;
    assign tx_push = tx_valid && (!tx_full || tx_pop);
    assign rx_pop  = rx_ready && !rx_empty;
    assign rx_push = (state == STORE) && (!rx_full || rx_pop);

    assign tx_ready       = !tx_full;
    assign rx_valid       = !rx_empty;
    assign rx_data        = rx_mem[rx_rd[ADDR_W-1:0]];
    assign spi_ready_send = (state == REQ);
    assign busy           = (state != IDLE) || !tx_empty;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr[ADDR_W-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push)
                tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)
                tx_rd <= tx_rd + PTR_ONE;
        end
    end

    // RX storage is cleared so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr <= '0;
            rx_rd <= '0;
            for (int i = 0; i < DEPTH; i++)
                rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr[ADDR_W-1:0]] <= spi_data_out;
                rx_wr <= rx_wr + PTR_ONE;
            end
            if (rx_pop)
                rx_rd <= rx_rd + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            spi_data_in <= '0;
        end else begin
            state <= state_next;
            if (tx_pop)
                spi_data_in <= tx_mem[tx_rd[ADDR_W-1:0]];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_pop)   state_next = REQ;
            REQ:     if (spi_ss)   state_next = XFER;
            XFER:    if (!spi_ss)  state_next = STORE;
            STORE:                 state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_byte_queue.sv
// Bench for spi_byte_queue: a small spi slave model echoes data_in + 8'h24, and
// scoreboards check every launched byte and every RX byte the host pops.
module tb_spi_byte_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] spi_data_in;
    logic       spi_ready_send;
    logic       spi_ss;
    logic [7:0] spi_data_out;
    logic       busy;
    logic [3:0] tx_count;
    logic [3:0] rx_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       model_enable = 1'b0;
    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];

    spi_byte_queue #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .spi_data_in(spi_data_in),
        .spi_ready_send(spi_ready_send),
        .spi_ss(spi_ss),
        .spi_data_out(spi_data_out),
        .busy(busy),
        .tx_count(tx_count),
        .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    // Offers one byte, waiting (bounded) for tx_ready; records expected launch and echo.
    task automatic apply_stimulus(input logic [7:0] b);
        int guard = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!tx_ready) begin
            report_timeout("push_wait");
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_exp.push_back(b);
        rx_exp.push_back(b + 8'h24);
    endtask

    task automatic wait_rx_count(input logic [3:0] n, input string name);
        int guard = 0;
        while (rx_count != n && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (rx_count != n)
            report_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((busy || rx_count != 0) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output({name, "_busy"}, busy, 0);
        check_output({name, "_rx_count"}, rx_count, 0);
    endtask

    task automatic wait_ss(input logic level, input string name);
        int guard = 0;
        @(negedge clk);
        while (spi_ss !== level && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (spi_ss !== level)
            report_timeout(name);
    endtask

    // Spi slave model: answers each request, checks the launched byte and its stability.
    initial begin
        logic [7:0] cap;
        spi_ss       = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (model_enable && spi_ready_send && !spi_ss) begin
                cap = spi_data_in;
                if (tx_exp.size() == 0) begin
                    check_output("launch_unexpected", 32'(cap), 32'hFFFF_FFFF);
                end else begin
                    check_output("launch_byte", cap, tx_exp.pop_front());
                end
                spi_ss = 1'b1;
                @(posedge clk); #1;
                check_output("ready_send_drop", spi_ready_send, 0);
                check_output("data_in_stable", spi_data_in, cap);
                repeat (2) begin
                    @(posedge clk); #1;
                end
                spi_data_out = cap + 8'h24;
                spi_ss       = 1'b0;
            end
        end
    end

    // RX monitor: every host pop is compared with the next expected echo.
    always @(negedge clk) begin
        if (rst && rx_valid && rx_ready) begin
            if (rx_exp.size() == 0)
                check_output("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else
                check_output("rx_byte", rx_data, rx_exp.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        rst      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_tx_ready", tx_ready, 1);
        check_output("rst_rx_valid", rx_valid, 0);
        check_output("rst_rx_data", rx_data, 0);
        check_output("rst_data_in", spi_data_in, 0);
        check_output("rst_ready_send", spi_ready_send, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_counts", {tx_count, rx_count}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] reset during REQ");
        apply_stimulus(8'hA5);
        guard = 0;
        while (!spi_ready_send && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("t1_req", spi_ready_send, 1);
        check_output("t1_data_in", spi_data_in, 8'hA5);
        #2;
        rst = 1'b0;
        #1;
        check_output("t1_ready_send_async", spi_ready_send, 0);
        check_output("t1_counts", {tx_count, rx_count}, 0);
        check_output("t1_busy", busy, 0);
        tx_exp.delete();
        rx_exp.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("t1_after_release", {busy, spi_ready_send}, 0);

        $display("[TB] single byte");
        model_enable = 1'b1;
        apply_stimulus(8'h13);
        wait_ss(1'b1, "t2_ss_rise");
        wait_ss(1'b0, "t2_ss_fall");
        @(posedge clk); #1;
        check_output("t2_rx_valid_early", rx_valid, 0);
        @(posedge clk); #1;
        check_output("t2_rx_valid", rx_valid, 1);
        check_output("t2_rx_data", rx_data, 8'h37);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        wait_idle("t2");

        $display("[TB] burst");
        model_enable = 1'b0;
        rx_ready     = 1'b1;
        for (int i = 1; i <= 9; i++)
            apply_stimulus(8'(i));
        check_output("t3_tx_count_full", tx_count, 8);
        check_output("t3_tx_ready", tx_ready, 0);
        check_output("t3_data_in", spi_data_in, 8'h01);
        model_enable = 1'b1;
        wait_idle("t3");
        rx_ready = 1'b0;

        $display("[TB] rx back-pressure");
        for (int i = 0; i < 10; i++)
            apply_stimulus(8'h20 + 8'(i));
        wait_rx_count(4'd8, "t4_rx_fill");
        repeat (20) @(posedge clk);
        #1;
        check_output("t4_rx_count", rx_count, 8);
        check_output("t4_tx_count", tx_count, 2);
        check_output("t4_no_req", spi_ready_send, 0);
        check_output("t4_busy", busy, 1);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        check_output("t4_rx_after_pop", rx_count, 7);
        guard = 0;
        while (!spi_ready_send && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("t4_ninth_req", spi_ready_send, 1);
        check_output("t4_ninth_byte", spi_data_in, 8'h28);
        rx_ready = 1'b1;
        wait_idle("t4");
        rx_ready = 1'b0;

        $display("[TB] simultaneous push/pop");
        for (int i = 0; i < 8; i++)
            apply_stimulus(8'h40 + 8'(i));
        wait_rx_count(4'd8, "t5_rx_fill");
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            apply_stimulus(8'h48 + 8'(i));
        check_output("t5_tx_full", {tx_ready, tx_count}, {1'b0, 4'd8});
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        tx_data  = 8'h50;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_exp.push_back(8'h50);
        rx_exp.push_back(8'h74);
        check_output("t5_tx_count_kept", tx_count, 8);
        check_output("t5_req", spi_ready_send, 1);
        check_output("t5_data_in", spi_data_in, 8'h48);
        check_output("t5_rx_count", rx_count, 7);
        wait_ss(1'b1, "t5_ss_rise");
        wait_ss(1'b0, "t5_ss_fall");
        @(posedge clk); #1;
        check_output("t5_rx_before_store", rx_count, 7);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        check_output("t5_rx_store_pop", rx_count, 7);
        rx_ready = 1'b1;
        wait_idle("t5");

        $display("[TB] empty/full guards");
        check_output("t6_rx_valid", rx_valid, 0);
        @(posedge clk); #1;
        check_output("t6_rx_count", rx_count, 0);
        rx_ready     = 1'b0;
        model_enable = 1'b0;
        for (int i = 0; i < 9; i++)
            apply_stimulus(8'h60 + 8'(i));
        check_output("t6_tx_full", tx_count, 8);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check_output("t6_push_full", {tx_ready, tx_count}, {1'b0, 4'd8});
        model_enable = 1'b1;
        rx_ready     = 1'b1;
        wait_idle("t6");
        rx_ready = 1'b0;

        check_output("end_tx_queue", tx_exp.size(), 0);
        check_output("end_rx_queue", rx_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
